frame_bank_scheduler: RTL and testbench
=======================================

// Module: frame_bank_scheduler
// PURPOSE
// - Ping-pong scheduler for the two video frame banks between the frame producer (decoder/loader) and the VGA scan-out.
// - Grants the producer a free bank, tracks which bank is full, and drives read_bank1/read_bank2 into VGA_top.
// - Generates the scan-out pixel address from VGA_top's ACTIVE, and swaps banks only at frame boundaries.
// - Holds each source frame for REPEAT display frames (30 fps source on a 60 Hz display).
// PARAMETERS
// - H_AREA       800                     visible pixels per line
// - V_AREA       600                     visible lines per frame
// - REPEAT       2                       display frames per source frame (>=1)
// - FRAME_PIXELS H_AREA*V_AREA           pixels per bank
// - ADDR_W       $clog2(FRAME_PIXELS)    width of rd_addr
// PORTS
// - CLK_40      in   1       pixel clock; the only clock
// - reset       in   1       synchronous, active-high
// - ACTIVE      in   1       from VGA_top; 1 = visible pixel this cycle
// - wr_req      in   1       producer has a decoded frame ready to write
// - wr_done     in   1       1-cycle pulse: producer finished filling granted bank
// - wr_grant    out  1       1-cycle pulse: bank wr_bank granted to producer
// - wr_bank     out  1       bank index being filled (valid while wr_busy)
// - wr_busy     out  1       a fill is in progress
// - read_bank1  out  1       scan-out reads bank 0 (to VGA_top)
// - read_bank2  out  1       scan-out reads bank 1 (to VGA_top)
// - rd_addr     out  ADDR_W  scan-out pixel address in displayed bank
// - frame_tick  out  1       1-cycle pulse on last visible pixel of each display frame
// - underrun    out  1       1-cycle pulse: swap due but no full bank, frame repeated
// BEHAVIOUR
// - All outputs registered. Reset values: wr_grant=0, wr_bank=0, wr_busy=0, read_bank1=0, read_bank2=0,
//   rd_addr=0, frame_tick=0, underrun=0. Internal state: full[1:0]=0, rep_cnt=0, disp FSM=D_WAIT, write FSM=W_IDLE.
// - Reset asserted mid-operation discards all bank contents and in-flight fills; no further output activity until released.
// - Bank b is free when: !full[b], b is not being filled, and b is not the displayed bank.
// - Write FSM:
//   - W_IDLE: if wr_req and a free bank exists, pulse wr_grant for one cycle, load wr_bank, set wr_busy, go to W_FILL.
//     Lowest free index wins. If no bank is free, wait; wr_grant stays 0.
//   - W_FILL: on wr_done, set full[wr_bank], clear wr_busy, go to W_IDLE. wr_req is ignored here.
//   - wr_done outside W_FILL is ignored. Next grant comes no earlier than 1 cycle after wr_done.
// - Display FSM:
//   - D_WAIT: read_bank1=read_bank2=0, rd_addr held at 0.
//     When any full[b] is set, disp=b (lowest index), clear full[b], rep_cnt=0, go to D_SHOW.
//     read_bank* becomes valid the next cycle.
//   - D_SHOW: exactly one of read_bank1/read_bank2 is high (bank 0 -> read_bank1).
//     Each ACTIVE cycle increments rd_addr; no change when ACTIVE=0.
//   - Frame end: ACTIVE and rd_addr==FRAME_PIXELS-1. On that cycle:
//     - rd_addr wraps to 0 and frame_tick pulses on the following cycle.
//     - If rep_cnt<REPEAT-1: rep_cnt++.
//     - Else, if the other bank is full: disp=other, clear its full flag, rep_cnt=0. The old bank becomes free.
//     - Else: pulse underrun, keep disp, leave rep_cnt at REPEAT-1 so the next frame end retries the swap.
//   - Swap takes effect on read_bank*/rd_addr in the cycle after the frame end, never mid-frame.
// - Simultaneous events:
//   - A wr_done for the other bank on the frame-end cycle counts as full (bypass), so the swap happens with no underrun.
//   - A grant and a swap in the same cycle are allowed. The freed bank becomes grantable the cycle after the swap.
// - rd_addr arithmetic is unsigned ADDR_W and never exceeds FRAME_PIXELS-1.
// TESTING (H_AREA=80, V_AREA=60 -> FRAME_PIXELS=4800, REPEAT=2)
// - Reset check: hold reset 3 cycles with ACTIVE=1 -> all outputs 0, rd_addr stays 0.
//   Assert reset mid-D_SHOW -> outputs return to 0 the next cycle.
// - First fill: wr_req=1 -> wr_grant pulse, wr_bank=0, wr_busy=1.
//   wr_done -> read_bank1=1 within 2 cycles; rd_addr counts 0..4799 over ACTIVE cycles.
// - Repeat/swap: fill bank 1 during display.
//   After 2 frame_ticks -> read_bank2=1, read_bank1=0, rd_addr=0; bank 0 grantable on the next wr_req.
// - Underrun: no second fill -> at the 2nd frame end underrun pulses and read_bank1 stays 1.
//   wr_done on bank 1 later -> swap at the next frame end.
// - Boundary: wr_done for bank 1 on the exact cycle rd_addr=4799 with rep_cnt=1 -> swap, no underrun.
// - Backpressure: both banks full/displayed, wr_req=1 -> no wr_grant until the swap; then wr_grant with the freed bank index.

Source files
------------

// File: rtl/frame_bank_scheduler.sv
// Ping-pong bank scheduler between frame producer and VGA scan-out; all outputs registered (1-cycle latency).
// Backpressure: wr_req waits with no wr_grant until a bank is neither full, filling, nor displayed.
module frame_bank_scheduler #(
  parameter int H_AREA       = 800,
  parameter int V_AREA       = 600,
  parameter int REPEAT       = 2,
  parameter int FRAME_PIXELS = H_AREA * V_AREA,
  parameter int ADDR_W       = $clog2(FRAME_PIXELS)
) (
  input  logic              CLK_40,
  input  logic              reset,
  input  logic              ACTIVE,
  input  logic              wr_req,
  input  logic              wr_done,
  output logic              wr_grant,
  output logic              wr_bank,
  output logic              wr_busy,
  output logic              read_bank1,
  output logic              read_bank2,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              frame_tick,
  output logic              underrun
);

  localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic {D_WAIT, D_SHOW} disp_state_t;
  typedef enum logic {W_IDLE, W_FILL} wr_state_t;

  disp_state_t       d_state, d_state_nxt;
  wr_state_t         w_state, w_state_nxt;
  logic [1:0]        full, full_nxt, full_set, full_clr, free;
  logic              disp, disp_nxt, other, other_full, fill_done;
  logic [REP_W-1:0]  rep_cnt, rep_cnt_nxt;
  logic              wr_grant_nxt, wr_bank_nxt, wr_busy_nxt;
  logic              read_bank1_nxt, read_bank2_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic              frame_tick_nxt, underrun_nxt;

  always_comb begin
    d_state_nxt    = d_state;
    w_state_nxt    = w_state;
    disp_nxt       = disp;
    rep_cnt_nxt    = rep_cnt;
    wr_grant_nxt   = 1'b0;
    wr_bank_nxt    = wr_bank;
    wr_busy_nxt    = wr_busy;
    rd_addr_nxt    = rd_addr;
    frame_tick_nxt = 1'b0;
    underrun_nxt   = 1'b0;
    full_set       = 2'b00;
    full_clr       = 2'b00;

    for (int b = 0; b < 2; b++) begin
      free[b] = !full[b] && !(wr_busy && (wr_bank == 1'(b))) &&
                !((d_state == D_SHOW) && (disp == 1'(b)));
    end

    fill_done  = (w_state == W_FILL) && wr_done;
    other      = ~disp;
    // A fill completing on the frame-end cycle is visible to the swap decision.
    other_full = full[other] || (fill_done && (wr_bank == other));

    case (w_state)
      W_IDLE: begin
        if (wr_req && (free != 2'b00)) begin
          wr_grant_nxt = 1'b1;
          wr_bank_nxt  = free[0] ? 1'b0 : 1'b1;
          wr_busy_nxt  = 1'b1;
          w_state_nxt  = W_FILL;
        end
      end
      W_FILL: begin
        if (wr_done) begin
          full_set[wr_bank] = 1'b1;
          wr_busy_nxt       = 1'b0;
          w_state_nxt       = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase

    case (d_state)
      D_WAIT: begin
        rd_addr_nxt = '0;
        if (full != 2'b00) begin
          disp_nxt           = full[0] ? 1'b0 : 1'b1;
          full_clr[disp_nxt] = 1'b1;
          rep_cnt_nxt        = '0;
          d_state_nxt        = D_SHOW;
        end
      end
      D_SHOW: begin
        if (ACTIVE) begin
          if (rd_addr == ADDR_LAST) begin
            rd_addr_nxt    = '0;
            frame_tick_nxt = 1'b1;
            if (rep_cnt < REP_LAST) begin
              rep_cnt_nxt = rep_cnt + 1'b1;
            end else if (other_full) begin
              disp_nxt        = other;
              full_clr[other] = 1'b1;
              rep_cnt_nxt     = '0;
            end else begin
              underrun_nxt = 1'b1;
            end
          end else begin
            rd_addr_nxt = rd_addr + 1'b1;
          end
        end
      end
      default: d_state_nxt = D_WAIT;
    endcase

    // Clear after set so a bypassed fill is consumed rather than left full.
    full_nxt       = (full | full_set) & ~full_clr;
    read_bank1_nxt = (d_state_nxt == D_SHOW) && (disp_nxt == 1'b0);
    read_bank2_nxt = (d_state_nxt == D_SHOW) && (disp_nxt == 1'b1);
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      d_state    <= D_WAIT;
      w_state    <= W_IDLE;
      full       <= 2'b00;
      disp       <= 1'b0;
      rep_cnt    <= '0;
      wr_grant   <= 1'b0;
      wr_bank    <= 1'b0;
      wr_busy    <= 1'b0;
      read_bank1 <= 1'b0;
      read_bank2 <= 1'b0;
      rd_addr    <= '0;
      frame_tick <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      d_state    <= d_state_nxt;
      w_state    <= w_state_nxt;
      full       <= full_nxt;
      disp       <= disp_nxt;
      rep_cnt    <= rep_cnt_nxt;
      wr_grant   <= wr_grant_nxt;
      wr_bank    <= wr_bank_nxt;
      wr_busy    <= wr_busy_nxt;
      read_bank1 <= read_bank1_nxt;
      read_bank2 <= read_bank2_nxt;
      rd_addr    <= rd_addr_nxt;
      frame_tick <= frame_tick_nxt;
      underrun   <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler with a small 80x60 frame and REPEAT=2.
module tb_frame_bank_scheduler;

  localparam int H_AREA = 80;
  localparam int V_AREA = 60;
  localparam int REPEAT = 2;
  localparam int FP     = H_AREA * V_AREA;
  localparam int AW     = $clog2(FP);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          active = 1'b0;
  logic          wr_req = 1'b0;
  logic          wr_done = 1'b0;
  logic          wr_grant, wr_bank, wr_busy, read_bank1, read_bank2;
  logic [AW-1:0] rd_addr;
  logic          frame_tick, underrun;

  int total = 0;
  int bad   = 0;

  frame_bank_scheduler #(.H_AREA(H_AREA), .V_AREA(V_AREA), .REPEAT(REPEAT)) dut (
    .CLK_40(clk), .reset(reset), .ACTIVE(active), .wr_req(wr_req), .wr_done(wr_done),
    .wr_grant(wr_grant), .wr_bank(wr_bank), .wr_busy(wr_busy),
    .read_bank1(read_bank1), .read_bank2(read_bank2), .rd_addr(rd_addr),
    .frame_tick(frame_tick), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, act, req, done;
    logic grant, bank, busy, rb1, rb2;
    int   addr;
    logic tick, und;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act_v, input int exp_v);
    total++;
    if (act_v != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic grant, input logic bank, input logic busy,
                         input logic rb1, input logic rb2, input int addr, input logic tick,
                         input logic und);
    chk({tag, ".wr_grant"},   int'(wr_grant),   int'(grant));
    chk({tag, ".wr_bank"},    int'(wr_bank),    int'(bank));
    chk({tag, ".wr_busy"},    int'(wr_busy),    int'(busy));
    chk({tag, ".read_bank1"}, int'(read_bank1), int'(rb1));
    chk({tag, ".read_bank2"}, int'(read_bank2), int'(rb2));
    chk({tag, ".rd_addr"},    int'(rd_addr),    addr);
    chk({tag, ".frame_tick"}, int'(frame_tick), int'(tick));
    chk({tag, ".underrun"},   int'(underrun),   int'(und));
  endtask

  // Drive ACTIVE for n cycles with wr_req/wr_done left as they are, counting output pulses.
  task automatic run_active(input int n, output int ticks, output int unders, output int grants);
    ticks = 0; unders = 0; grants = 0;
    active = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (frame_tick) ticks++;
      if (underrun)   unders++;
      if (wr_grant)   grants++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tk, un, gr;

    //              rst act req done grant bank busy rb1 rb2 addr tick und
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5, 1'b0, 1'b0};

    // Reset, first fill of bank 0, display start, second grant to bank 1.
    for (int i = 0; i < 14; i++) begin
      reset = vecs[i].rst; active = vecs[i].act; wr_req = vecs[i].req; wr_done = vecs[i].done;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].bank, vecs[i].busy, vecs[i].rb1,
              vecs[i].rb2, vecs[i].addr, vecs[i].tick, vecs[i].und);
    end
    wr_req = 1'b0; wr_done = 1'b0;

    // Repeat then swap: bank 1 completes early, bank 0 shown twice.
    active = 1'b1; wr_done = 1'b1; step(); wr_done = 1'b0;
    chk("rep.busy_clr", int'(wr_busy), 0);
    run_active(4793, tk, un, gr);
    chk("rep.addr_last1", int'(rd_addr), FP - 1);
    chk("rep.no_tick_mid", tk, 0);
    step();
    chk_all("rep.end1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    run_active(4799, tk, un, gr);
    chk("rep.addr_last2", int'(rd_addr), FP - 1);
    chk("rep.no_tick_mid2", tk, 0);
    step();
    chk_all("rep.swap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    wr_req = 1'b1; step(); wr_req = 1'b0;
    chk_all("rep.freed_grant", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0);

    // Underrun: bank 0 still filling when bank 1's repeats are used up.
    run_active(4798, tk, un, gr);
    step();
    chk_all("und.end1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    run_active(4799, tk, un, gr);
    chk("und.none_mid", un, 0);
    step();
    chk_all("und.pulse", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b1);
    step();
    chk_all("und.after", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    wr_done = 1'b1; step(); wr_done = 1'b0;
    chk("und.fill_done", int'(wr_busy), 0);
    run_active(4797, tk, un, gr);
    chk("und.addr_last", int'(rd_addr), FP - 1);
    step();
    chk_all("und.retry_swap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);

    // Boundary: wr_done for bank 1 lands on the frame-end cycle itself.
    wr_req = 1'b1; step(); wr_req = 1'b0;
    chk_all("bnd.grant1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    run_active(4798, tk, un, gr);
    step();
    chk("bnd.tick1", int'(frame_tick), 1);
    run_active(4799, tk, un, gr);
    chk("bnd.addr_last", int'(rd_addr), FP - 1);
    wr_done = 1'b1; step(); wr_done = 1'b0;
    chk_all("bnd.bypass_swap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);

    // Backpressure: bank 0 full, bank 1 displayed, wr_req held.
    wr_req = 1'b1; step(); wr_req = 1'b0;
    chk_all("bp.grant0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    wr_done = 1'b1; step(); wr_done = 1'b0;
    chk("bp.full0", int'(wr_busy), 0);
    wr_req = 1'b1;
    run_active(4797, tk, un, gr);
    chk("bp.no_grant_a", gr, 0);
    step();
    chk("bp.end1_no_grant", int'(wr_grant), 0);
    run_active(4799, tk, un, gr);
    chk("bp.no_grant_b", gr, 0);
    step();
    chk_all("bp.swap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    step();
    chk_all("bp.freed_grant", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    wr_req = 1'b0;

    // Reset in the middle of display and fill.
    run_active(10, tk, un, gr);
    reset = 1'b1; step();
    chk_all("rst.mid1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    step();
    chk_all("rst.mid2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    reset = 1'b0; step();
    chk_all("rst.released", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    wr_req = 1'b1; step(); wr_req = 1'b0;
    chk_all("rst.regrant", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
